// File: rtl/au_gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy, load, terminal count and change strobe.
// Optional macro AU_GRAY_CNT_CHECK_EN compiles in a sticky single-bit-transition checker on g.
module au_gray_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             tc,
    output logic             chg,
    output logic             err
);

    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_G = INIT_B ^ (INIT_B >> 1);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] g_q;
    logic             chg_q;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] g_next;

    always_comb begin
        b_next = b_q;
        if (ld) begin
            b_next = ld_val;
        end else if (en) begin
            b_next = up_dn ? (b_q + WIDTH'(1)) : (b_q - WIDTH'(1));
        end
        g_next = b_next ^ (b_next >> 1);
    end

    // g is registered from b_next so b and g always move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q   <= INIT_B;
            g_q   <= INIT_G;
            chg_q <= 1'b0;
        end else begin
            b_q   <= b_next;
            g_q   <= g_next;
            chg_q <= (g_next != g_q);
        end
    end

    assign b   = b_q;
    assign g   = g_q;
    assign chg = chg_q;
    assign tc  = up_dn ? (b_q == '1) : (b_q == '0);

`ifdef AU_GRAY_CNT_CHECK_EN
    logic [WIDTH-1:0] g_prev_q;
    logic             step_q;
    logic             err_q;

    // step_q marks that the most recent update was a count step, so loads and resets are skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_prev_q <= INIT_G;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            g_prev_q <= g_q;
            step_q   <= en & ~ld;
            if (step_q && ($countones(g_q ^ g_prev_q) != 1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_au_gray_counter.sv
// Scoreboard bench for au_gray_counter: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_au_gray_counter;

    typedef struct {
        bit         sel;
        int         id;
        logic [3:0] b;
        logic [3:0] g;
        logic       tc;
        logic       chg;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, en0 = 1'b0, up0 = 1'b1, ld0 = 1'b0;
    logic [3:0] lv0 = '0;
    logic [3:0] b0, g0;
    logic       tc0, chg0, err0;

    logic       rst1 = 1'b1, en1 = 1'b0, up1 = 1'b1, ld1 = 1'b0;
    logic [3:0] lv1 = '0;
    logic [3:0] b1, g1;
    logic       tc1, chg1, err1;

    au_gray_counter #(.WIDTH(4), .INIT(0)) u0 (
        .clk(clk), .rst(rst0), .en(en0), .up_dn(up0), .ld(ld0), .ld_val(lv0),
        .b(b0), .g(g0), .tc(tc0), .chg(chg0), .err(err0)
    );

    au_gray_counter #(.WIDTH(4), .INIT(3)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .up_dn(up1), .ld(ld1), .ld_val(lv1),
        .b(b1), .g(g1), .tc(tc1), .chg(chg1), .err(err1)
    );

    exp_t       q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         vec_id = 0;
    logic [3:0] gtab [16];

    initial begin
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    end

    // Drive one cycle of inputs and queue the state expected after the coming edge.
    task automatic drive(input bit sel, input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv,
                         input logic [3:0] eb, input logic ec, input logic ee);
        exp_t x;
        @(negedge clk);
        if (sel == 1'b0) begin
            rst0 = r; en0 = e; up0 = u; ld0 = l; lv0 = lv;
        end else begin
            rst1 = r; en1 = e; up1 = u; ld1 = l; lv1 = lv;
        end
        x.sel = sel;
        x.id  = vec_id;
        x.b   = eb;
        x.g   = gtab[eb];
        x.tc  = u ? (eb == 4'hF) : (eb == 4'h0);
        x.chg = ec;
        x.err = ee;
        q.push_back(x);
        vec_id++;
    endtask

    initial begin : monitor
        exp_t       x;
        logic [3:0] ab, ag;
        logic       atc, achg, aerr;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.sel == 1'b0) begin
                    ab = b0; ag = g0; atc = tc0; achg = chg0; aerr = err0;
                end else begin
                    ab = b1; ag = g1; atc = tc1; achg = chg1; aerr = err1;
                end
                n_chk++;
                if (ab === x.b && ag === x.g && atc === x.tc && achg === x.chg && aerr === x.err) begin
                    n_pass++;
                end else begin
                    $display("FAIL dut%0d vec %0d: got b=%h g=%h tc=%b chg=%b err=%b, expected b=%h g=%h tc=%b chg=%b err=%b",
                             x.sel, x.id, ab, ag, atc, achg, aerr, x.b, x.g, x.tc, x.chg, x.err);
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0] mb;
        // reset state, tc in both directions
        drive(0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0);
        drive(0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        // up-count through wrap: 17 steps from 0
        for (int i = 1; i <= 17; i++) begin
            mb = 4'(i);
            drive(0, 0, 1, 1, 0, 4'h0, mb, 1, 0);
        end
        // down-count from 1 through wrap: 0, F, E
        drive(0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0);
        drive(0, 0, 1, 0, 0, 4'h0, 4'hF, 1, 0);
        drive(0, 0, 1, 0, 0, 4'h0, 4'hE, 1, 0);
        // load 5, then load A with en high (load wins), reload A, hold
        drive(0, 0, 0, 1, 1, 4'h5, 4'h5, 1, 0);
        drive(0, 0, 1, 1, 1, 4'hA, 4'hA, 1, 0);
        drive(0, 0, 1, 1, 1, 4'hA, 4'hA, 0, 0);
        drive(0, 0, 0, 1, 0, 4'h3, 4'hA, 0, 0);
        // count step right after loads
        drive(0, 0, 1, 0, 0, 4'h0, 4'h9, 1, 0);
        drive(0, 0, 0, 0, 0, 4'h0, 4'h9, 0, 0);

`ifdef AU_GRAY_CNT_CHECK_EN
        mb = 4'h9;
        for (int i = 0; i < 16; i++) begin
            logic u;
            u  = 1'($urandom_range(0, 1));
            mb = u ? mb + 4'h1 : mb - 4'h1;
            drive(0, 0, 1, u, 0, 4'h0, mb, 1, 0);
        end
        @(posedge clk);
        #2;
        force u0.g_q = u0.g_prev_q ^ 4'b0011;
        #1;
        release u0.g_q;
        drive(0, 0, 0, 1, 0, 4'h0, mb, 1, 1);
        drive(0, 0, 0, 1, 0, 4'h0, mb, 0, 1);
        drive(0, 0, 0, 1, 0, 4'h0, mb, 0, 1);
        drive(0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0);
`endif

        // INIT=3 instance: reset, count up to 9, then reset mid-count
        drive(1, 1, 0, 1, 0, 4'h0, 4'h3, 0, 0);
        for (int i = 4; i <= 9; i++) begin
            mb = 4'(i);
            drive(1, 0, 1, 1, 0, 4'h0, mb, 1, 0);
        end
        drive(1, 1, 1, 1, 0, 4'h0, 4'h3, 0, 0);
        drive(1, 0, 0, 1, 0, 4'h0, 4'h3, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
            n_chk++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
